// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer BRAM arbiter: scanout reads have hard priority, writer fills
// the back buffer in free cycles; front/back select swaps only on a new-frame pulse.
module fb_scanout_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              nf_in,
    input  logic              scan_req_in,
    input  logic [ADDR_W-1:0] scan_addr_in,
    output logic              scan_rvalid_out,
    output logic [DATA_W-1:0] scan_rdata_out,
    input  logic              wr_valid_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ready_out,
    input  logic              swap_req_in,
    output logic              swap_pending_out,
    output logic              swap_done_out,
    output logic              front_sel_out,
    output logic [15:0]       wr_stall_cnt_out,
    output logic              mem_en_out,
    output logic              mem_we_out,
    output logic [ADDR_W:0]   mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in
);

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_SWAP_PEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                front_sel_q, front_sel_d;
    logic                swap_done_q, swap_done_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MEM_LAT:0]    tag_q, tag_d;
    logic                wr_ready_s;
    logic                wr_grant_s;
    logic                wr_stall_s;

    // Next-state logic: port grant, read-tag pipe, swap FSM and stall counter
    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        swap_done_d = 1'b0;
        stall_cnt_d = stall_cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // Writes are held off while a swap is armed so none can straddle the toggle
        wr_ready_s = (state_q == ST_RUN) & ~scan_req_in & rst_in;
        wr_grant_s = wr_valid_in & wr_ready_s;
        wr_stall_s = wr_valid_in & ~wr_ready_s;

        if (scan_req_in) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {front_sel_q, scan_addr_in};
        end else if (wr_grant_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {~front_sel_q, wr_addr_in};
            mem_wdata_d = wr_data_in;
        end else begin
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
        end

        tag_d = {tag_q[MEM_LAT-1:0], scan_req_in};

        case (state_q)
            ST_RUN: begin
                if (swap_req_in) begin
                    state_d = ST_SWAP_PEND;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SWAP_PEND: begin
                if (nf_in) begin
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_SWAP_PEND;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (nf_in) begin
            stall_cnt_d = 16'd0;
        end else if (wr_stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_RUN;
            front_sel_q <= 1'b0;
            swap_done_q <= 1'b0;
            stall_cnt_q <= 16'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {(ADDR_W+1){1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            tag_q       <= {(MEM_LAT+1){1'b0}};
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            stall_cnt_q <= stall_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_q       <= tag_d;
        end
    end

    // Read data is gated by reset so every output reads 0 while held in reset
    assign scan_rvalid_out  = tag_q[MEM_LAT];
    assign scan_rdata_out   = rst_in ? mem_rdata_in : {DATA_W{1'b0}};
    assign wr_ready_out     = wr_ready_s;
    assign swap_pending_out = (state_q == ST_SWAP_PEND);
    assign swap_done_out    = swap_done_q;
    assign front_sel_out    = front_sel_q;
    assign wr_stall_cnt_out = stall_cnt_q;
    assign mem_en_out       = mem_en_q;
    assign mem_we_out       = mem_we_q;
    assign mem_addr_out     = mem_addr_q;
    assign mem_wdata_out    = mem_wdata_q;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter with a 2-cycle BRAM model whose read data is
// the low address half XOR 16'hA5C3.
module tb_fb_scanout_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        nf_in;
    logic        scan_req_in;
    logic [16:0] scan_addr_in;
    logic        scan_rvalid_out;
    logic [15:0] scan_rdata_out;
    logic        wr_valid_in;
    logic [16:0] wr_addr_in;
    logic [15:0] wr_data_in;
    logic        wr_ready_out;
    logic        swap_req_in;
    logic        swap_pending_out;
    logic        swap_done_out;
    logic        front_sel_out;
    logic [15:0] wr_stall_cnt_out;
    logic        mem_en_out;
    logic        mem_we_out;
    logic [17:0] mem_addr_out;
    logic [15:0] mem_wdata_out;
    logic [15:0] mem_rdata_in;

    logic [17:0] s1_addr = 18'd0;
    logic [17:0] s2_addr = 18'd0;

    int vectors = 0;
    int miscompares = 0;

    fb_scanout_arbiter #(.ADDR_W(17), .DATA_W(16), .MEM_LAT(2)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .nf_in            (nf_in),
        .scan_req_in      (scan_req_in),
        .scan_addr_in     (scan_addr_in),
        .scan_rvalid_out  (scan_rvalid_out),
        .scan_rdata_out   (scan_rdata_out),
        .wr_valid_in      (wr_valid_in),
        .wr_addr_in       (wr_addr_in),
        .wr_data_in       (wr_data_in),
        .wr_ready_out     (wr_ready_out),
        .swap_req_in      (swap_req_in),
        .swap_pending_out (swap_pending_out),
        .swap_done_out    (swap_done_out),
        .front_sel_out    (front_sel_out),
        .wr_stall_cnt_out (wr_stall_cnt_out),
        .mem_en_out       (mem_en_out),
        .mem_we_out       (mem_we_out),
        .mem_addr_out     (mem_addr_out),
        .mem_wdata_out    (mem_wdata_out),
        .mem_rdata_in     (mem_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: data appears two cycles after the enable cycle
    always @(posedge clk_in) begin
        s1_addr <= mem_addr_out;
        s2_addr <= s1_addr;
    end
    assign mem_rdata_in = s2_addr[15:0] ^ 16'hA5C3;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in = 1'b0; nf_in = 1'b0; scan_req_in = 1'b0; scan_addr_in = 17'd0;
        wr_valid_in = 1'b0; wr_addr_in = 17'd0; wr_data_in = 16'd0; swap_req_in = 1'b0;
        repeat (3) tick;
        chk("rst_en",      32'(mem_en_out),       32'd0);
        chk("rst_we",      32'(mem_we_out),       32'd0);
        chk("rst_addr",    32'(mem_addr_out),     32'd0);
        chk("rst_front",   32'(front_sel_out),    32'd0);
        chk("rst_wready",  32'(wr_ready_out),     32'd0);
        chk("rst_pending", 32'(swap_pending_out), 32'd0);
        chk("rst_done",    32'(swap_done_out),    32'd0);
        chk("rst_stall",   32'(wr_stall_cnt_out), 32'd0);
        chk("rst_rvalid",  32'(scan_rvalid_out),  32'd0);
        chk("rst_rdata",   32'(scan_rdata_out),   32'd0);
        rst_in = 1'b1;
        tick;

        // single read, front buffer 0
        scan_req_in = 1'b1; scan_addr_in = 17'h00123;
        tick;
        scan_req_in = 1'b0;
        chk("rd_en",   32'(mem_en_out),   32'd1);
        chk("rd_we",   32'(mem_we_out),   32'd0);
        chk("rd_addr", 32'(mem_addr_out), 32'h00123);
        tick;
        chk("rd_rvalid_t2", 32'(scan_rvalid_out), 32'd0);
        tick;
        chk("rd_rvalid_t3", 32'(scan_rvalid_out), 32'd1);
        chk("rd_rdata_t3",  32'(scan_rdata_out),  32'hA4E0);
        tick;
        chk("rd_rvalid_t4", 32'(scan_rvalid_out), 32'd0);

        // back-to-back reads
        scan_req_in = 1'b1; scan_addr_in = 17'h00010;
        tick;
        scan_addr_in = 17'h00011;
        tick;
        scan_req_in = 1'b0;
        tick;
        chk("b2b_rvalid0", 32'(scan_rvalid_out), 32'd1);
        chk("b2b_rdata0",  32'(scan_rdata_out),  32'hA5D3);
        tick;
        chk("b2b_rvalid1", 32'(scan_rvalid_out), 32'd1);
        chk("b2b_rdata1",  32'(scan_rdata_out),  32'hA5D2);
        tick;
        chk("b2b_rvalid2", 32'(scan_rvalid_out), 32'd0);

        // contention: reads block the writer for 10 cycles
        scan_req_in = 1'b1; scan_addr_in = 17'h00200;
        wr_valid_in = 1'b1; wr_addr_in = 17'h0AAAA; wr_data_in = 16'h1234;
        #1;
        chk("cont_wready", 32'(wr_ready_out), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("cont_no_write", 32'(mem_we_out), 32'd0);
        end
        chk("cont_stall10", 32'(wr_stall_cnt_out), 32'd10);
        scan_req_in = 1'b0;
        #1;
        chk("rel_wready", 32'(wr_ready_out), 32'd1);
        tick;
        wr_valid_in = 1'b0;
        chk("rel_en",    32'(mem_en_out),       32'd1);
        chk("rel_we",    32'(mem_we_out),       32'd1);
        chk("rel_addr",  32'(mem_addr_out),     32'h2AAAA);
        chk("rel_wdata", 32'(mem_wdata_out),    32'h1234);
        chk("rel_stall", 32'(wr_stall_cnt_out), 32'd10);
        tick;
        chk("idle_en",   32'(mem_en_out),   32'd0);
        chk("idle_addr", 32'(mem_addr_out), 32'h2AAAA);

        // nf_in clears the stall counter, no swap armed
        nf_in = 1'b1;
        tick;
        nf_in = 1'b0;
        chk("nf_stall_clr", 32'(wr_stall_cnt_out), 32'd0);
        chk("nf_no_swap",   32'(front_sel_out),    32'd0);

        // swap armed for 100 cycles, writer held off
        swap_req_in = 1'b1;
        tick;
        swap_req_in = 1'b0;
        wr_valid_in = 1'b1; wr_addr_in = 17'h00055; wr_data_in = 16'h5555;
        for (int i = 0; i < 100; i++) begin
            #1;
            chk("pend_hold", {30'd0, swap_pending_out, wr_ready_out}, 32'd2);
            tick;
        end
        chk("pend_stall100", 32'(wr_stall_cnt_out), 32'd100);
        chk("pend_no_write", 32'(mem_we_out),       32'd0);
        nf_in = 1'b1;
        tick;
        nf_in = 1'b0; wr_valid_in = 1'b0;
        chk("swap_front",   32'(front_sel_out),    32'd1);
        chk("swap_done",    32'(swap_done_out),    32'd1);
        chk("swap_pending", 32'(swap_pending_out), 32'd0);
        chk("swap_stall0",  32'(wr_stall_cnt_out), 32'd0);
        tick;
        chk("swap_done_pulse", 32'(swap_done_out), 32'd0);
        chk("swap_front_hold", 32'(front_sel_out), 32'd1);

        // after swap: reads hit buffer 1, writes buffer 0
        scan_req_in = 1'b1; scan_addr_in = 17'h00123;
        tick;
        scan_req_in = 1'b0;
        chk("f1_rd_addr", 32'(mem_addr_out), 32'h20123);
        wr_valid_in = 1'b1; wr_addr_in = 17'h00077; wr_data_in = 16'hBEEF;
        tick;
        wr_valid_in = 1'b0;
        chk("f1_wr_we",    32'(mem_we_out),    32'd1);
        chk("f1_wr_addr",  32'(mem_addr_out),  32'h00077);
        chk("f1_wr_wdata", 32'(mem_wdata_out), 32'hBEEF);
        tick;
        chk("f1_rvalid", 32'(scan_rvalid_out), 32'd1);
        chk("f1_rdata",  32'(scan_rdata_out),  32'hA4E0);

        // mid-operation reset drops in-flight read and armed swap
        swap_req_in = 1'b1;
        tick;
        swap_req_in = 1'b0;
        chk("mr_pending", 32'(swap_pending_out), 32'd1);
        scan_req_in = 1'b1; scan_addr_in = 17'h00300;
        tick;
        scan_req_in = 1'b0;
        chk("mr_en_before", 32'(mem_en_out), 32'd1);
        rst_in = 1'b0;
        #1;
        chk("mr_en",      32'(mem_en_out),       32'd0);
        chk("mr_addr",    32'(mem_addr_out),     32'd0);
        chk("mr_pending0",32'(swap_pending_out), 32'd0);
        chk("mr_front",   32'(front_sel_out),    32'd0);
        chk("mr_wready",  32'(wr_ready_out),     32'd0);
        chk("mr_rvalid",  32'(scan_rvalid_out),  32'd0);
        tick;
        rst_in = 1'b1;
        tick;
        chk("mr_drop1", 32'(scan_rvalid_out), 32'd0);
        tick;
        chk("mr_drop2", 32'(scan_rvalid_out), 32'd0);
        nf_in = 1'b1;
        tick;
        nf_in = 1'b0;
        chk("mr_nf_front", 32'(front_sel_out), 32'd0);
        chk("mr_nf_done",  32'(swap_done_out), 32'd0);

        // swap_req and nf_in together: no toggle until the next nf_in
        swap_req_in = 1'b1; nf_in = 1'b1;
        tick;
        swap_req_in = 1'b0; nf_in = 1'b0;
        chk("edge_front",   32'(front_sel_out),    32'd0);
        chk("edge_pending", 32'(swap_pending_out), 32'd1);
        chk("edge_done",    32'(swap_done_out),    32'd0);
        repeat (5) tick;
        chk("edge_wait_front", 32'(front_sel_out), 32'd0);
        nf_in = 1'b1;
        tick;
        nf_in = 1'b0;
        chk("edge_toggle", 32'(front_sel_out), 32'd1);
        chk("edge_done2",  32'(swap_done_out), 32'd1);

        // stall counter saturation
        nf_in = 1'b1;
        tick;
        nf_in = 1'b0;
        chk("sat_start", 32'(wr_stall_cnt_out), 32'd0);
        scan_req_in = 1'b1; wr_valid_in = 1'b1;
        repeat (65534) tick;
        chk("sat_fffe", 32'(wr_stall_cnt_out), 32'h0000FFFE);
        tick;
        chk("sat_ffff", 32'(wr_stall_cnt_out), 32'h0000FFFF);
        repeat (4465) tick;
        chk("sat_hold", 32'(wr_stall_cnt_out), 32'h0000FFFF);
        nf_in = 1'b1;
        tick;
        nf_in = 1'b0;
        chk("sat_nf_clr", 32'(wr_stall_cnt_out), 32'd0);
        scan_req_in = 1'b0; wr_valid_in = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
